// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 16-bit iterative divider (alu_div16) and its
// subtract-step helper (div_sub_step).
//   DIV_W      operand / result width
//   DIV_ITERS  restoring iterations per division (one per quotient bit)
//   CNT_W      width of the iteration counter
//   state_t    divider control states: IDLE, CALC, FINISH
//   cond_neg   two's-complement negate when 'neg' is set, else pass through
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DIV_W     = 16;
  localparam int DIV_ITERS = 16;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONES = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Negation is done modulo 2^DIV_W, so 0x8000 maps to itself. Used both to
  // take magnitudes (0x8000 -> 32768 read as unsigned) and to re-apply signs.
  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] x,
                                                input logic             neg);
    cond_neg = neg ? (~x + DIV_ONE) : x;
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// ---------------------------------------------------------------------------
// div_sub_step
// One trial subtraction of the restoring divider: diff = a - b computed as
// a + ~b + 1 with an explicit ripple carry chain.
//   a        input  W  shifted partial remainder
//   b        input  W  divisor magnitude (zero-extended)
//   diff     output W  a - b modulo 2^W
//   non_neg  output 1  1 when a >= b (carry out of the chain)
// ---------------------------------------------------------------------------
module div_sub_step #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         non_neg
);

  logic [W-1:0] b_inv;
  logic         carry;

  assign b_inv = ~b;

  // The carry is walked through a loop variable rather than a vector so the
  // chain stays a plain combinational ripple without self-referencing nets.
  always_comb begin
    diff  = '0;
    carry = 1'b1;
    for (int i = 0; i < W; i++) begin
      diff[i] = a[i] ^ b_inv[i] ^ carry;
      carry   = (a[i] & b_inv[i]) | (carry & (a[i] ^ b_inv[i]));
    end
    // With both operands unsigned, a final carry of 1 means no borrow.
    non_neg = carry;
  end

endmodule

// File: rtl/alu_div16.sv
// ---------------------------------------------------------------------------
// alu_div16
// 16-bit signed/unsigned restoring divider, one quotient bit per clock.
//   clk          input   1   sole clock, rising edge
//   rst          input   1   synchronous active-high reset
//   start        input   1   request, only honoured in IDLE
//   is_signed    input   1   1 = two's-complement operands
//   dividend     input   16  numerator, sampled with start
//   divisor      input   16  denominator, sampled with start
//   busy         output  1   high during the 16 iteration cycles
//   done         output  1   one-cycle pulse with valid results
//   quotient     output  16  result, held until the next result
//   remainder    output  16  result, held until the next result
//   div_by_zero  output  1   flags a zero divisor, cleared on next start
// Timing: start cycle = 0, busy in cycles 1..16, done in cycle 17.
// A zero divisor skips the iterations and reports done in cycle 1.
// ---------------------------------------------------------------------------
module alu_div16
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [DIV_W-1:0] rem_reg;        // partial remainder
  logic [DIV_W-1:0] quo_reg;        // dividend bits shifting out, quotient in
  logic [DIV_W-1:0] dvs_mag_reg;    // divisor magnitude
  logic             signed_reg;
  logic             q_neg_reg;      // raw sign XOR; gated by signed_reg
  logic             r_neg_reg;      // raw dividend sign; gated by signed_reg
  logic [DIV_W-1:0] quotient_reg;
  logic [DIV_W-1:0] remainder_reg;
  logic             dbz_reg;
  logic             done_reg;

  logic             take_start;
  logic             divisor_zero;
  logic [DIV_W-1:0] dividend_mag;
  logic [DIV_W-1:0] divisor_mag;

  logic [DIV_W:0]   step_a;
  logic [DIV_W:0]   step_b;
  logic [DIV_W:0]   step_diff;
  logic             step_non_neg;
  logic             diff_msb_unused;
  logic [DIV_W-1:0] rem_step;
  logic [DIV_W-1:0] quo_step;
  logic             last_iter;

  // -------------------------------------------------------------------------
  // Operand capture helpers
  // -------------------------------------------------------------------------
  assign take_start   = (state_reg == IDLE) && start;
  assign divisor_zero = (divisor == '0);
  assign dividend_mag = cond_neg(dividend, is_signed & dividend[DIV_W-1]);
  assign divisor_mag  = cond_neg(divisor,  is_signed & divisor[DIV_W-1]);

  // -------------------------------------------------------------------------
  // One restoring step: shift {rem,quo} left by one, trial-subtract divisor.
  // The shifted remainder can reach 17 bits, hence the 17-bit subtractor.
  // -------------------------------------------------------------------------
  assign step_a = {rem_reg, quo_reg[DIV_W-1]};
  assign step_b = {1'b0, dvs_mag_reg};

  div_sub_step #(
    .W (DIV_W + 1)
  ) u_sub_step (
    .a       (step_a),
    .b       (step_b),
    .diff    (step_diff),
    .non_neg (step_non_neg)
  );

  // A kept difference is always below the divisor, so its top bit is zero.
  assign diff_msb_unused = step_diff[DIV_W];

  assign rem_step  = step_non_neg ? step_diff[DIV_W-1:0] : step_a[DIV_W-1:0];
  assign quo_step  = {quo_reg[DIV_W-2:0], step_non_neg};
  assign last_iter = (cnt_reg == LAST_ITER);

  // -------------------------------------------------------------------------
  // Control FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = divisor_zero ? FINISH : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and result registers
  // The signed results are formed on the edge that enters FINISH, so the
  // FINISH cycle presents registered, sign-corrected outputs with done.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_mag_reg   <= '0;
      signed_reg    <= 1'b0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      if (take_start) begin
        cnt_reg     <= '0;
        rem_reg     <= '0;
        quo_reg     <= dividend_mag;
        dvs_mag_reg <= divisor_mag;
        signed_reg  <= is_signed;
        q_neg_reg   <= dividend[DIV_W-1] ^ divisor[DIV_W-1];
        r_neg_reg   <= dividend[DIV_W-1];
        dbz_reg     <= 1'b0;

        // Zero divisor: results are fixed, reported in the very next cycle.
        if (divisor_zero) begin
          quotient_reg  <= DIV_ONES;
          remainder_reg <= dividend;
          dbz_reg       <= 1'b1;
          done_reg      <= 1'b1;
        end
      end

      if (state_reg == CALC) begin
        rem_reg <= rem_step;
        quo_reg <= quo_step;
        cnt_reg <= cnt_reg + 1'b1;

        if (last_iter) begin
          quotient_reg  <= cond_neg(quo_step, signed_reg & q_neg_reg);
          remainder_reg <= cond_neg(rem_step, signed_reg & r_neg_reg);
          done_reg      <= 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy        = (state_reg == CALC);
  assign done        = done_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_alu_div16.sv
// ---------------------------------------------------------------------------
// tb_alu_div16
// Self-checking bench for alu_div16. A cycle-level model derives expected
// outputs from plain integer division; a compare process checks every cycle.
// Directed operations pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_alu_div16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  alu_div16 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: an accepted request produces its answer after a fixed
  // number of cycles; outputs are what was last reported.
  // -------------------------------------------------------------------------
  bit          m_active  = 1'b0;
  int          m_done_at = 0;
  logic [15:0] m_q       = '0;
  logic [15:0] m_r       = '0;
  bit          m_dbz     = 1'b0;
  logic [15:0] vis_q     = '0;
  logic [15:0] vis_r     = '0;
  bit          vis_dbz   = 1'b0;
  bit          exp_done  = 1'b0;
  bit          exp_busy  = 1'b0;
  bit          chk_en    = 1'b0;

  always @(posedge clk) begin
    bit accept;
    int sa, sb, qi, ri;
    if (rst) begin
      m_active = 1'b0;
      vis_q    = '0;
      vis_r    = '0;
      vis_dbz  = 1'b0;
    end else begin
      accept = !m_active && (start === 1'b1);
      if (m_active && cyc == m_done_at) m_active = 1'b0;
      if (accept) begin
        if (divisor == 16'h0000) begin
          m_q   = 16'hFFFF;
          m_r   = dividend;
          m_dbz = 1'b1;
        end else if (is_signed) begin
          sa    = $signed(dividend);
          sb    = $signed(divisor);
          qi    = sa / sb;
          ri    = sa % sb;
          m_q   = qi[15:0];
          m_r   = ri[15:0];
          m_dbz = 1'b0;
        end else begin
          m_q   = dividend / divisor;
          m_r   = dividend % divisor;
          m_dbz = 1'b0;
        end
        m_active  = 1'b1;
        m_done_at = cyc + ((divisor == 16'h0000) ? 1 : 17);
        vis_dbz   = 1'b0;
      end
    end
    cyc      = cyc + 1;
    exp_done = m_active && (cyc == m_done_at);
    exp_busy = m_active && (cyc < m_done_at);
    if (exp_done) begin
      vis_q   = m_q;
      vis_r   = m_r;
      vis_dbz = m_dbz;
    end
    chk_en = 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", done, exp_done);
      chk("busy", busy, exp_busy);
      chk("div_by_zero", div_by_zero, vis_dbz);
      if (!exp_busy) begin
        chk("quotient", quotient, vis_q);
        chk("remainder", remainder, vis_r);
      end
      if (exp_done)
        $display("txn cycle=%0d q=%h r=%h dbz=%0d", cyc, vis_q, vis_r, vis_dbz);
    end
  end

  // -------------------------------------------------------------------------
  // Directed helpers
  // -------------------------------------------------------------------------
  task automatic wait_done(input string name, input int t0, input logic [15:0] eq,
                           input logic [15:0] er, input bit edbz, input int elat);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        chk({name, "_latency"}, cyc - t0, elat);
        chk({name, "_q"}, quotient, eq);
        chk({name, "_r"}, remainder, er);
        chk({name, "_dbz"}, div_by_zero, edbz);
        chk({name, "_model_q"}, vis_q, eq);
        chk({name, "_model_r"}, vis_r, er);
        $display("op %s q=%h r=%h dbz=%0d lat=%0d", name, quotient, remainder,
                 div_by_zero, cyc - t0);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  task automatic run_op(input string name, input bit s, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] eq,
                        input logic [15:0] er, input bit edbz, input int elat);
    int t0;
    @(negedge clk);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    t0        = cyc;
    wait_done(name, t0, eq, er, edbz, elat);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       pick = 16'h0000;
      1:       pick = 16'hFFFF;
      2:       pick = 16'h8000;
      3:       pick = 16'h0001;
      4:       pick = 16'($urandom_range(0, 15));
      default: pick = 16'($urandom);
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int t0;
    int n_done;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_q", quotient, 16'h0000);
    chk("reset_r", remainder, 16'h0000);
    chk("reset_dbz", div_by_zero, 1'b0);
    rst = 1'b0;

    run_op("u100_7",     1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17);
    run_op("s_m7_2",     1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 17);
    run_op("s_7_m2",     1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 17);
    run_op("s_dbz",      1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);
    run_op("u_dbz",      1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);
    run_op("s_min_m1",   1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17);
    run_op("u_ffff_1",   1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17);

    // Reset at cycle 8 aborts the operation; restart right after reset.
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 16'h00FF;
    divisor   = 16'h0003;
    t0        = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", quotient, 16'h0000);
    chk("abort_r", remainder, 16'h0000);
    chk("abort_dbz", div_by_zero, 1'b0);
    start     = 1'b1;
    dividend  = 16'h00FF;
    divisor   = 16'h0003;
    t0        = cyc;
    wait_done("restart", t0, 16'h0055, 16'h0000, 1'b0, 17);

    // Starts at cycles 5 and 17 of a running operation are ignored.
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 16'd1000;
    divisor   = 16'd9;
    t0        = cyc;
    n_done    = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        chk("ignore_latency", cyc - t0, 17);
        chk("ignore_q", quotient, 16'd111);
        chk("ignore_r", remainder, 16'd1);
      end
      start     = (k == 5) || (k == 17);
      is_signed = 1'($urandom_range(0, 1));
      dividend  = 16'($urandom);
      divisor   = 16'($urandom_range(1, 65535));
    end
    start = 1'b0;
    chk("ignore_done_count", n_done, 1);
    $display("op ignore_starts dones=%0d", n_done);

    // Randomized traffic, including occasional resets and zero divisors.
    repeat (2500) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) == 0);
      is_signed = 1'($urandom_range(0, 1));
      dividend  = pick();
      divisor   = pick();
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
